datapath: RTL and testbench
===========================

Name: datapath

Overview:
- 32-bit single-bus processor datapath for the phase-2 CPU.
- Contains R0..R15, PC, IR, MAR, MDR, Y, a 64-bit Z, Hi/Lo, the select-and-encode logic, the C sign-extender, the bus multiplexer and the ALU.
- An external control unit, or a bench, drives one-hot strobes each cycle; the block exposes all internal state for observation.

Parameters:
- none (bus width fixed at 32; Z and ALUout fixed at 64)

Ports:
- clk  in  1  rising-edge clock for all registers
- clear  in  1  asynchronous active-low reset; clears every register to 0
- PCout, Zlowout, MDRout, Cout, BAout, Rout  in  1 each  bus-source enables
- Gra, Grb, Grc  in  1 each  select IR field Ra/Rb/Rc
- Rin, MARin, Zin, PCin, MDRin, IRin, Yin  in  1 each  register load enables
- IncPC  in  1  ALU computes bus+4
- read  in  1  MDR input mux select: 1=Mdatain, 0=bus
- ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT  in  1 each  ALU op strobes
- Mdatain  in  32  memory read data
- R0..R15  out  32 each  general registers
- Hi, Lo  out  32 each  multiply/divide result registers
- PC, IR, MAR, MDR  out  32 each  special registers
- Z  out  64  ALU result register
- ALUout  out  64  combinational ALU result
- bus_mux_out  out  32  current bus value
- C_sign_ext  out  32  IR[18:0] sign-extended from bit 18
- Rins, Routs  out  16 each  decoded register load/drive enables

Behaviour:
- Registers: all are posedge clk. clear=0 asynchronously forces every register to 0, including R0..R15, Hi, Lo, PC, IR, MAR, MDR, Y and Z. Reset wins over any load in the same cycle.
- IR fields: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Select-and-encode: index = Gra?Ra : Grb?Rb : Grc?Rc : 0 (Gra highest priority).
  - Rins = onehot(index) when Rin, else 0.
  - Routs = onehot(index) when Rout or BAout, else 0.
  - With no Gr* asserted, index 0 is used.
- BAout: drives the selected register onto the bus, except index 0 drives 32'h0 (base-address rule). Rout drives R0 normally.
- Bus mux: combinational. Priority when several sources are asserted: MDRout > Zlowout (Z[31:0]) > PCout > Cout (C_sign_ext) > Routs-selected register. No source asserted -> bus=0.
- Register loads (next edge):
  - MDRin: MDR <= read ? Mdatain : bus.
  - MARin, PCin, IRin, Yin: the respective register <= bus.
  - Zin: Z <= ALUout.
  - Rins[i]: Ri <= bus.
- Hi/Lo: this block has no load path for them; they hold 0 after reset.
- ALU: A=Y, B=bus. Unless noted, ALUout[31:0]=result and ALUout[63:32]=0. Priority when several op strobes are asserted, highest first:
  - IncPC: B+4
  - ADD: A+B, carry discarded
  - SUB: A-B, two's-complement wrap
  - AND: A&B
  - OR: A|B
  - SHR: logical A>>B[4:0]
  - SHL: A<<B[4:0]
  - ROR: rotate A right by B[4:0]
  - ROL: rotate A left by B[4:0]
  - NEG: -B
  - NOT: ~B
  - no strobe: ALUout=0
- Shift and rotate amounts of 0 return A unchanged.
- Latency: the ALU is combinational; a result is visible in Z one edge after Zin.

Test Plan:
- Reset, then load PC: clear low mid-run -> all registers 0 immediately. Release clear; read+MDRin, Mdatain=0 -> MDR=0. Then MDRout+PCin -> PC=0.
- Fetch: PCout+MARin+IncPC+Zin -> MAR=0, Z=4. Then Zlowout+PCin with read+MDRin, Mdatain=0x01000085 -> PC=4, MDR=0x01000085. Then MDRout+IRin -> IR=0x01000085, C_sign_ext=0x00000085.
- ld address calculation: Grb+BAout+Yin (Rb=0) -> Routs=0x0001, bus=0, Y=0. Then Cout+ADD+Zin -> Z=0x85. Then Zlowout+MARin -> MAR=0x85.
- ld writeback: read+MDRin, Mdatain=2 -> MDR=2. Then MDRout+Gra+Rin (Ra=2) -> Rins=0x0004, R2=2, other registers unchanged.
- ALU sweep with Y=0x80000001 and bus=4:
  - SHR -> 0x08000000
  - SHL -> 0x00000010
  - ROR -> 0x18000000
  - ROL -> 0x00000018
  - SUB -> 0x7FFFFFFD
  - NEG -> 0xFFFFFFFC
  - NOT -> 0xFFFFFFFB
  - ALUout[63:32]=0 for every op
- Sign extension and BAout: IR=0x0007FFFF -> C_sign_ext=0xFFFFFFFF; IR=0x0003FFFF -> C_sign_ext=0x0003FFFF. Load R5=0x1234, then Grb+BAout with Rb=5 -> bus=0x1234.

Source files
------------

// File: rtl/datapath_if.sv
// rtl/datapath_if.sv - control strobes and observation signals of the single-bus CPU datapath.
interface datapath_if;
    logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
    logic        Gra, Grb, Grc;
    logic        Rin, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        IncPC, read;
    logic        ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
    logic [31:0] Mdatain;
    logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7;
    logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15;
    logic [31:0] Hi, Lo, PC, IR, MAR, MDR;
    logic [63:0] Z, ALUout;
    logic [31:0] bus_mux_out, C_sign_ext;
    logic [15:0] Rins, Routs;

    modport master (
        output PCout, Zlowout, MDRout, Cout, BAout, Rout, Gra, Grb, Grc,
               Rin, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, read,
               ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, Mdatain,
        input  R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15,
               Hi, Lo, PC, IR, MAR, MDR, Z, ALUout, bus_mux_out, C_sign_ext, Rins, Routs
    );

    modport slave (
        input  PCout, Zlowout, MDRout, Cout, BAout, Rout, Gra, Grb, Grc,
               Rin, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, read,
               ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, Mdatain,
        output R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15,
               Hi, Lo, PC, IR, MAR, MDR, Z, ALUout, bus_mux_out, C_sign_ext, Rins, Routs
    );
endinterface

// File: rtl/datapath.sv
// rtl/datapath.sv - 32-bit single-bus datapath: register file, select/encode, bus mux and ALU.
module datapath (
    input  logic      clk,
    input  logic      clear,
    datapath_if.slave dp
);
    logic [31:0] r_q [16];
    logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
    logic [63:0] z_q;

    logic [31:0] mdr_d, c_ext, bus, ror_res, rol_res;
    logic [63:0] alu;
    logic [3:0]  sel_idx;
    logic [15:0] sel_onehot, rins;
    logic [4:0]  sh;
    logic        unused_opcode;

    assign unused_opcode = ^ir_q[31:27];
    assign c_ext         = {{13{ir_q[18]}}, ir_q[18:0]};

    always_comb begin
        sel_idx = 4'd0;
        if (dp.Gra)      sel_idx = ir_q[26:23];
        else if (dp.Grb) sel_idx = ir_q[22:19];
        else if (dp.Grc) sel_idx = ir_q[18:15];
    end

    assign sel_onehot = 16'd1 << sel_idx;
    assign rins       = dp.Rin ? sel_onehot : 16'd0;
    assign dp.Rins    = rins;
    assign dp.Routs   = (dp.Rout || dp.BAout) ? sel_onehot : 16'd0;

    // BAout on index 0 reads as a zero base address rather than R0.
    always_comb begin
        bus = 32'd0;
        if (dp.MDRout)                       bus = mdr_q;
        else if (dp.Zlowout)                 bus = z_q[31:0];
        else if (dp.PCout)                   bus = pc_q;
        else if (dp.Cout)                    bus = c_ext;
        else if (dp.BAout && sel_idx == 4'd0) bus = 32'd0;
        else if (dp.Rout || dp.BAout)        bus = r_q[sel_idx];
    end

    assign sh      = bus[4:0];
    assign ror_res = 32'({y_q, y_q} >> sh);
    assign rol_res = 32'(({y_q, y_q} << sh) >> 32);

    always_comb begin
        alu = 64'd0;
        if (dp.IncPC)    alu[31:0] = bus + 32'd4;
        else if (dp.ADD) alu[31:0] = y_q + bus;
        else if (dp.SUB) alu[31:0] = y_q - bus;
        else if (dp.AND) alu[31:0] = y_q & bus;
        else if (dp.OR)  alu[31:0] = y_q | bus;
        else if (dp.SHR) alu[31:0] = y_q >> sh;
        else if (dp.SHL) alu[31:0] = y_q << sh;
        else if (dp.ROR) alu[31:0] = ror_res;
        else if (dp.ROL) alu[31:0] = rol_res;
        else if (dp.NEG) alu[31:0] = 32'd0 - bus;
        else if (dp.NOT) alu[31:0] = ~bus;
    end

    assign mdr_d = dp.read ? dp.Mdatain : bus;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= 32'd0;
            pc_q  <= 32'd0;
            ir_q  <= 32'd0;
            mar_q <= 32'd0;
            mdr_q <= 32'd0;
            y_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            z_q   <= 64'd0;
        end else begin
            if (dp.MDRin) mdr_q <= mdr_d;
            if (dp.MARin) mar_q <= bus;
            if (dp.PCin)  pc_q  <= bus;
            if (dp.IRin)  ir_q  <= bus;
            if (dp.Yin)   y_q   <= bus;
            if (dp.Zin)   z_q   <= alu;
            for (int i = 0; i < 16; i++) begin
                if (rins[i]) r_q[i] <= bus;
            end
            hi_q <= hi_q;
            lo_q <= lo_q;
        end
    end

    assign dp.R0  = r_q[0];
    assign dp.R1  = r_q[1];
    assign dp.R2  = r_q[2];
    assign dp.R3  = r_q[3];
    assign dp.R4  = r_q[4];
    assign dp.R5  = r_q[5];
    assign dp.R6  = r_q[6];
    assign dp.R7  = r_q[7];
    assign dp.R8  = r_q[8];
    assign dp.R9  = r_q[9];
    assign dp.R10 = r_q[10];
    assign dp.R11 = r_q[11];
    assign dp.R12 = r_q[12];
    assign dp.R13 = r_q[13];
    assign dp.R14 = r_q[14];
    assign dp.R15 = r_q[15];

    assign dp.Hi          = hi_q;
    assign dp.Lo          = lo_q;
    assign dp.PC          = pc_q;
    assign dp.IR          = ir_q;
    assign dp.MAR         = mar_q;
    assign dp.MDR         = mdr_q;
    assign dp.Z           = z_q;
    assign dp.ALUout      = alu;
    assign dp.bus_mux_out = bus;
    assign dp.C_sign_ext  = c_ext;
endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed and randomized checks of the datapath against a behavioural model.
module tb_datapath;
    logic clk;
    logic clear;
    int   n_assert;
    int   n_fail;
    logic [31:0] m_r [16];

    datapath_if dif ();

    datapath u_dut (
        .clk   (clk),
        .clear (clear),
        .dp    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dif.PCout = 0; dif.Zlowout = 0; dif.MDRout = 0; dif.Cout = 0; dif.BAout = 0; dif.Rout = 0;
        dif.Gra = 0; dif.Grb = 0; dif.Grc = 0;
        dif.Rin = 0; dif.MARin = 0; dif.Zin = 0; dif.PCin = 0; dif.MDRin = 0; dif.IRin = 0; dif.Yin = 0;
        dif.IncPC = 0; dif.read = 0;
        dif.ADD = 0; dif.SUB = 0; dif.AND = 0; dif.OR = 0; dif.SHR = 0;
        dif.SHL = 0; dif.ROR = 0; dif.ROL = 0; dif.NEG = 0; dif.NOT = 0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle();
        dif.read = 1; dif.MDRin = 1; dif.Mdatain = v;
        tick();
        idle();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        dif.MDRout = 1; dif.IRin = 1;
        tick();
        idle();
    endtask

    task automatic set_op(input int op);
        case (op)
            0: dif.IncPC = 1;
            1: dif.ADD = 1;
            2: dif.SUB = 1;
            3: dif.AND = 1;
            4: dif.OR = 1;
            5: dif.SHR = 1;
            6: dif.SHL = 1;
            7: dif.ROR = 1;
            8: dif.ROL = 1;
            9: dif.NEG = 1;
            default: dif.NOT = 1;
        endcase
    endtask

    function automatic logic [63:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int s;
        s = int'(b % 32);
        case (op)
            0: r = b + 4;
            1: r = a + b;
            2: r = a - b;
            3: r = a & b;
            4: r = a | b;
            5: r = a >> s;
            6: r = a << s;
            7: r = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            8: r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            9: r = ~b + 1;
            default: r = b ^ 32'hFFFF_FFFF;
        endcase
        return {32'd0, r};
    endfunction

    function automatic logic [31:0] get_r(input int i);
        case (i)
            0: return dif.R0;   1: return dif.R1;   2: return dif.R2;   3: return dif.R3;
            4: return dif.R4;   5: return dif.R5;   6: return dif.R6;   7: return dif.R7;
            8: return dif.R8;   9: return dif.R9;   10: return dif.R10; 11: return dif.R11;
            12: return dif.R12; 13: return dif.R13; 14: return dif.R14; default: return dif.R15;
        endcase
    endfunction

    int          sweep_op  [7] = '{5, 6, 7, 8, 2, 9, 10};
    logic [31:0] sweep_exp [7] = '{32'h0800_0000, 32'h0000_0010, 32'h1800_0000, 32'h0000_0018,
                                   32'h7FFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFB};

    initial begin
        logic [31:0] a, b, v;
        int op, idx;
        n_assert = 0;
        n_fail   = 0;
        idle();
        dif.Mdatain = 32'd0;
        clear = 1'b0;
        repeat (2) tick();
        clear = 1'b1;
        tick();

        // make state non-zero, then clear asynchronously between edges
        load_mdr(32'hDEAD_BEEF);
        dif.MDRout = 1; dif.PCin = 1; dif.IRin = 1; dif.MARin = 1; dif.Yin = 1;
        dif.ADD = 1; dif.Zin = 1; dif.Gra = 1; dif.Rin = 1;
        tick();
        idle();
        chk("pre_reset_pc", dif.PC, 32'hDEAD_BEEF);
        chk("pre_reset_r0", dif.R0, 32'hDEAD_BEEF);
        clear = 1'b0;
        #2;
        chk("reset_pc", dif.PC, 0);
        chk("reset_ir", dif.IR, 0);
        chk("reset_mar", dif.MAR, 0);
        chk("reset_mdr", dif.MDR, 0);
        chk("reset_z", dif.Z, 0);
        chk("reset_hi", dif.Hi, 0);
        chk("reset_lo", dif.Lo, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("reset_r%0d", i), get_r(i), 0);
        for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
        tick();
        clear = 1'b1;
        tick();

        load_mdr(32'd0);
        chk("mdr_zero", dif.MDR, 0);
        dif.MDRout = 1; dif.PCin = 1;
        tick();
        idle();
        chk("pc_zero", dif.PC, 0);

        // fetch
        dif.PCout = 1; dif.MARin = 1; dif.IncPC = 1; dif.Zin = 1;
        settle();
        chk("fetch_alu", dif.ALUout, 64'd4);
        tick();
        idle();
        chk("fetch_mar", dif.MAR, 0);
        chk("fetch_z", dif.Z, 64'd4);
        dif.Zlowout = 1; dif.PCin = 1; dif.read = 1; dif.MDRin = 1; dif.Mdatain = 32'h0100_0085;
        tick();
        idle();
        chk("fetch_pc", dif.PC, 32'd4);
        chk("fetch_mdr", dif.MDR, 32'h0100_0085);
        dif.MDRout = 1; dif.IRin = 1;
        tick();
        idle();
        chk("fetch_ir", dif.IR, 32'h0100_0085);
        chk("fetch_cext", dif.C_sign_ext, 32'h0000_0085);

        // ld address calculation and writeback
        dif.Grb = 1; dif.BAout = 1; dif.Yin = 1;
        settle();
        chk("ld_routs", dif.Routs, 16'h0001);
        chk("ld_bus_ba0", dif.bus_mux_out, 0);
        tick();
        idle();
        dif.Cout = 1; dif.ADD = 1; dif.Zin = 1;
        tick();
        idle();
        chk("ld_z", dif.Z, 64'h85);
        dif.Zlowout = 1; dif.MARin = 1;
        tick();
        idle();
        chk("ld_mar", dif.MAR, 32'h85);
        load_mdr(32'd2);
        chk("ld_mdr", dif.MDR, 32'd2);
        dif.MDRout = 1; dif.Gra = 1; dif.Rin = 1;
        settle();
        chk("ld_rins", dif.Rins, 16'h0004);
        tick();
        idle();
        m_r[2] = 32'd2;
        for (int i = 0; i < 16; i++) chk($sformatf("ld_r%0d", i), get_r(i), m_r[i]);

        // ALU sweep with Y=0x80000001, bus=4
        load_mdr(32'h8000_0001);
        dif.MDRout = 1; dif.Yin = 1;
        tick();
        load_mdr(32'd4);
        for (int i = 0; i < 7; i++) begin
            idle();
            dif.MDRout = 1;
            set_op(sweep_op[i]);
            settle();
            chk($sformatf("sweep_op%0d", sweep_op[i]), dif.ALUout, {32'd0, sweep_exp[i]});
        end
        idle();
        dif.MDRout = 1; dif.IncPC = 1; dif.ADD = 1;
        settle();
        chk("alu_prio_incpc", dif.ALUout, 64'd8);
        idle();
        dif.MDRout = 1; dif.PCout = 1;
        settle();
        chk("bus_prio_mdr", dif.bus_mux_out, 32'd4);
        idle();
        dif.Zlowout = 1; dif.PCout = 1;
        settle();
        chk("bus_prio_z", dif.bus_mux_out, 32'h85);
        idle();
        settle();
        chk("bus_none", dif.bus_mux_out, 0);
        chk("alu_none", dif.ALUout, 0);

        // sign extension
        load_ir(32'h0007_FFFF);
        chk("cext_neg", dif.C_sign_ext, 32'hFFFF_FFFF);
        load_ir(32'h0003_FFFF);
        chk("cext_pos", dif.C_sign_ext, 32'h0003_FFFF);

        // BAout on a non-zero index, and R0 via Rout vs BAout
        load_ir(32'h02A8_0000);
        load_mdr(32'h1234);
        dif.MDRout = 1; dif.Gra = 1; dif.Rin = 1;
        tick();
        idle();
        m_r[5] = 32'h1234;
        chk("r5_load", dif.R5, 32'h1234);
        dif.Grb = 1; dif.BAout = 1;
        settle();
        chk("ba_r5_bus", dif.bus_mux_out, 32'h1234);
        chk("ba_r5_routs", dif.Routs, 16'h0020);
        idle();
        load_ir(32'h0000_0000);
        load_mdr(32'h55);
        dif.MDRout = 1; dif.Gra = 1; dif.Rin = 1;
        tick();
        idle();
        m_r[0] = 32'h55;
        dif.Grb = 1; dif.Rout = 1;
        settle();
        chk("rout_r0", dif.bus_mux_out, 32'h55);
        idle();
        dif.Grb = 1; dif.BAout = 1;
        settle();
        chk("baout_r0", dif.bus_mux_out, 0);
        idle();

        // randomized ALU ops through Z
        for (int it = 0; it < 40; it++) begin
            a  = $urandom;
            b  = (it % 2 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            op = $urandom_range(0, 10);
            load_mdr(a);
            dif.MDRout = 1; dif.Yin = 1;
            tick();
            load_mdr(b);
            dif.MDRout = 1; dif.Zin = 1;
            set_op(op);
            settle();
            chk($sformatf("rnd_alu_op%0d", op), dif.ALUout, alu_ref(op, a, b));
            tick();
            idle();
            chk($sformatf("rnd_z_op%0d", op), dif.Z, alu_ref(op, a, b));
        end

        // randomized register writes via Ra, then Grc readback
        for (int it = 0; it < 12; it++) begin
            idx = $urandom_range(0, 15);
            v   = $urandom;
            load_ir(32'(idx) << 23 | 32'(idx) << 15);
            load_mdr(v);
            dif.MDRout = 1; dif.Gra = 1; dif.Rin = 1;
            tick();
            idle();
            m_r[idx] = v;
            dif.Grc = 1; dif.Rout = 1;
            settle();
            chk($sformatf("rnd_rout_r%0d", idx), dif.bus_mux_out, v);
            idle();
        end
        for (int i = 0; i < 16; i++) chk($sformatf("rnd_r%0d", i), get_r(i), m_r[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
